// File: rtl/can_rx_buffer_pkg.sv
// Shared types and constants for the CAN receive frame store.
package can_rx_buffer_pkg;

    localparam int unsigned CAN_MAX_DLC = 8;

    // Stored frame; occupancy lives in the FIFO count, so there is no valid bit
    typedef struct packed {
        logic [10:0]     id;
        logic [3:0]      dlc;
        logic [7:0][7:0] data;
    } rx_frame_t;

    // Clamp DLC to 8 and zero payload bytes at or beyond the clamped length
    function automatic rx_frame_t make_rx_frame(input logic [10:0]     id,
                                                input logic [3:0]      dlc,
                                                input logic [7:0][7:0] data);
        rx_frame_t f;
        f.id   = id;
        f.dlc  = (dlc > 4'(CAN_MAX_DLC)) ? 4'(CAN_MAX_DLC) : dlc;
        f.data = '0;
        for (int i = 0; i < CAN_MAX_DLC; i++) begin
            if (4'(i) < f.dlc) begin
                f.data[i] = data[i];
            end
        end
        return f;
    endfunction

endpackage

// File: rtl/can_rx_filter.sv
// Combinational standard-ID acceptance filter: a mask bit of 1 forces that ID bit to match.
module can_rx_filter (
    input  logic [10:0] rx_id,
    input  logic [10:0] acc_code,
    input  logic [10:0] acc_mask,
    output logic        pass
);

    assign pass = (((rx_id ^ acc_code) & acc_mask) == 11'd0);

endmodule

// File: rtl/can_rx_buffer.sv
// CAN receive frame store: acceptance filter in front of an N-deep first-word fall-through FIFO
// with sticky overrun flag and saturating drop counter.
// Optional feature macro: CAN_RX_FILTER_EN (undefined: every rx_valid frame is accepted).
module can_rx_buffer
    import can_rx_buffer_pkg::*;
#(
    parameter  int unsigned N     = 8,
    localparam int unsigned CNT_W = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_valid,
    input  logic [10:0]      rx_id,
    input  logic [3:0]       rx_dlc,
    input  logic [7:0][7:0]  rx_data,
    input  logic [10:0]      acc_code,
    input  logic [10:0]      acc_mask,
    input  logic             rd_en,
    output logic             rd_valid,
    output logic [10:0]      rd_id,
    output logic [3:0]       rd_dlc,
    output logic [7:0][7:0]  rd_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             overrun,
    input  logic             ovr_clr,
    output logic [7:0]       drop_cnt
);

    localparam int unsigned PTR_W = $clog2(N);

    rx_frame_t        mem [N];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             overrun_q;
    logic [7:0]       drop_cnt_q;

    logic      filter_pass;
    logic      accept, push, pop, drop;
    rx_frame_t wr_frame, head;

`ifdef CAN_RX_FILTER_EN
    can_rx_filter u_filter (
        .rx_id    (rx_id),
        .acc_code (acc_code),
        .acc_mask (acc_mask),
        .pass     (filter_pass)
    );
`else
    logic unused_acc;
    assign unused_acc  = ^{acc_code, acc_mask};
    assign filter_pass = 1'b1;
`endif

    assign full   = (count_q == CNT_W'(N));
    assign empty  = (count_q == '0);
    assign accept = rx_valid & filter_pass;
    assign pop    = rd_en & ~empty;
    // A pop in the same cycle frees a slot even when full
    assign push   = accept & (~full | pop);
    assign drop   = accept & full & ~pop;

    assign wr_frame = make_rx_frame(rx_id, rx_dlc, rx_data);
    assign head     = mem[rd_ptr_q];

    // Frame storage, deliberately not reset
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr_q] <= wr_frame;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_q <= count_q + CNT_W'(1);
            else if (pop && !push) count_q <= count_q - CNT_W'(1);
        end
    end

    // Overrun flag and drop counter; a drop takes priority over a coincident clear
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_q  <= 1'b0;
            drop_cnt_q <= '0;
        end else if (drop) begin
            overrun_q <= 1'b1;
            if (ovr_clr)                drop_cnt_q <= 8'd1;
            else if (drop_cnt_q != '1)  drop_cnt_q <= drop_cnt_q + 8'd1;
        end else if (ovr_clr) begin
            overrun_q  <= 1'b0;
            drop_cnt_q <= '0;
        end
    end

    // Read port is gated so stale storage never shows while empty
    always_comb begin
        rd_valid = ~empty;
        rd_id    = '0;
        rd_dlc   = '0;
        rd_data  = '0;
        if (rd_valid) begin
            rd_id   = head.id;
            rd_dlc  = head.dlc;
            rd_data = head.data;
        end
    end

    assign count    = count_q;
    assign overrun  = overrun_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_can_rx_buffer.sv
// Directed self-checking bench for can_rx_buffer (N = 8).
module tb_can_rx_buffer;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            rx_valid = 1'b0;
    logic [10:0]     rx_id = '0;
    logic [3:0]      rx_dlc = '0;
    logic [7:0][7:0] rx_data = '0;
    logic [10:0]     acc_code = '0;
    logic [10:0]     acc_mask = '0;
    logic            rd_en = 1'b0;
    logic            ovr_clr = 1'b0;
    logic            rd_valid;
    logic [10:0]     rd_id;
    logic [3:0]      rd_dlc;
    logic [7:0][7:0] rd_data;
    logic [3:0]      count;
    logic            full, empty, overrun;
    logic [7:0]      drop_cnt;

    int n_pass = 0;
    int n_total = 0;

    can_rx_buffer #(.N(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_valid (rx_valid),
        .rx_id    (rx_id),
        .rx_dlc   (rx_dlc),
        .rx_data  (rx_data),
        .acc_code (acc_code),
        .acc_mask (acc_mask),
        .rd_en    (rd_en),
        .rd_valid (rd_valid),
        .rd_id    (rd_id),
        .rd_dlc   (rd_dlc),
        .rd_data  (rd_data),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .overrun  (overrun),
        .ovr_clr  (ovr_clr),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [10:0] id, input logic [3:0] dlc, input logic [63:0] data);
        rx_valid = 1'b1;
        rx_id    = id;
        rx_dlc   = dlc;
        rx_data  = data;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
    endtask

    initial begin
        // Reset state
        step();
        step();
        rst = 1'b0;
        check("rst_count", 64'(count), 64'd0);
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_valid", 64'(rd_valid), 64'd0);
        check("rst_full", 64'(full), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        check("rst_drop", 64'(drop_cnt), 64'd0);
        check("rst_rd_id", 64'(rd_id), 64'd0);

        // Basic ordering; first frame visible the cycle after its push
        push(11'h123, 4'd2, 64'h0807_0605_0403_0201);
        check("lat_valid", 64'(rd_valid), 64'd1);
        check("lat_id", 64'(rd_id), 64'h123);
        check("b_dlc", 64'(rd_dlc), 64'd2);
        check("b_data", rd_data, 64'h0201);
        push(11'h045, 4'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        push(11'h7FF, 4'd8, 64'h1122_3344_5566_7788);
        check("b_count3", 64'(count), 64'd3);
        check("b_head0", 64'(rd_id), 64'h123);
        pop();
        check("b_head1", 64'(rd_id), 64'h045);
        check("b_data1", rd_data, 64'h0);
        check("b_count2", 64'(count), 64'd2);
        pop();
        check("b_head2", 64'(rd_id), 64'h7FF);
        check("b_data2", rd_data, 64'h1122_3344_5566_7788);
        pop();
        check("b_count0", 64'(count), 64'd0);
        check("b_empty", 64'(empty), 64'd1);
        pop();
        check("underflow_cnt", 64'(count), 64'd0);
        check("underflow_ovr", 64'(overrun), 64'd0);

        // DLC clamp and byte zeroing
        push(11'h010, 4'd12, 64'hAAAA_AAAA_AAAA_AAAA);
        check("clamp_dlc", 64'(rd_dlc), 64'd8);
        check("clamp_data", rd_data, 64'hAAAA_AAAA_AAAA_AAAA);
        pop();
        push(11'h011, 4'd3, 64'hAAAA_AAAA_AAAA_AAAA);
        check("dlc3_dlc", 64'(rd_dlc), 64'd3);
        check("dlc3_data", rd_data, 64'h0000_0000_00AA_AAAA);
        pop();

        // Fill to full (pointers currently at 5), then overrun on the 9th
        for (int i = 0; i < 8; i++) push(11'h100 + 11'(i), 4'd1, 64'(i));
        check("full_flag", 64'(full), 64'd1);
        check("full_count", 64'(count), 64'd8);
        check("full_noovr", 64'(overrun), 64'd0);
        push(11'h1FF, 4'd1, 64'h55);
        check("ovr_flag", 64'(overrun), 64'd1);
        check("ovr_drop", 64'(drop_cnt), 64'd1);
        check("ovr_count", 64'(count), 64'd8);
        check("ovr_head", 64'(rd_id), 64'h100);

        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        check("clr_flag", 64'(overrun), 64'd0);
        check("clr_drop", 64'(drop_cnt), 64'd0);

        // Simultaneous push and pop while full
        rd_en = 1'b1;
        push(11'h200, 4'd2, 64'hBEEF);
        rd_en = 1'b0;
        check("sim_count", 64'(count), 64'd8);
        check("sim_ovr", 64'(overrun), 64'd0);
        check("sim_full", 64'(full), 64'd1);
        for (int i = 1; i < 8; i++) begin
            check($sformatf("drain_id%0d", i), 64'(rd_id), 64'h100 + 64'(i));
            check($sformatf("drain_data%0d", i), rd_data, 64'(i));
            pop();
        end
        check("drain_last_id", 64'(rd_id), 64'h200);
        check("drain_last_data", rd_data, 64'hBEEF);
        pop();
        check("drain_empty", 64'(empty), 64'd1);

        // Acceptance filter
        acc_code = 11'h120;
        acc_mask = 11'h7F0;
        push(11'h125, 4'd0, 64'h0);
        push(11'h135, 4'd0, 64'h0);
`ifdef CAN_RX_FILTER_EN
        check("filt_count", 64'(count), 64'd1);
        check("filt_head", 64'(rd_id), 64'h125);
        pop();
`else
        check("nofilt_count", 64'(count), 64'd2);
        check("nofilt_head", 64'(rd_id), 64'h125);
        pop();
        check("nofilt_second", 64'(rd_id), 64'h135);
        pop();
`endif
        check("filt_empty", 64'(empty), 64'd1);
        acc_code = '0;
        acc_mask = '0;

        // Reset mid-traffic with 5 frames and a pending overrun
        for (int i = 0; i < 9; i++) push(11'h300 + 11'(i), 4'd0, 64'h0);
        pop();
        pop();
        pop();
        check("pre_rst_count", 64'(count), 64'd5);
        check("pre_rst_ovr", 64'(overrun), 64'd1);
        rst      = 1'b1;
        rx_valid = 1'b1;
        rd_en    = 1'b1;
        step();
        rst      = 1'b0;
        rx_valid = 1'b0;
        rd_en    = 1'b0;
        check("mid_rst_count", 64'(count), 64'd0);
        check("mid_rst_empty", 64'(empty), 64'd1);
        check("mid_rst_ovr", 64'(overrun), 64'd0);
        check("mid_rst_drop", 64'(drop_cnt), 64'd0);
        check("mid_rst_valid", 64'(rd_valid), 64'd0);

        // ovr_clr coincident with a drop: the drop wins
        for (int i = 0; i < 10; i++) push(11'h400 + 11'(i), 4'd0, 64'h0);
        check("pre_clr_drop", 64'(drop_cnt), 64'd2);
        ovr_clr = 1'b1;
        push(11'h4FF, 4'd0, 64'h0);
        ovr_clr = 1'b0;
        check("clr_drop_ovr", 64'(overrun), 64'd1);
        check("clr_drop_cnt", 64'(drop_cnt), 64'd1);
        check("clr_drop_head", 64'(rd_id), 64'h400);
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        check("clr_only_ovr", 64'(overrun), 64'd0);
        check("clr_only_cnt", 64'(drop_cnt), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
